cam_assoc_store: RTL and testbench
==================================

// Module: cam_assoc_store
// PURPOSE
//  Parametrised content-addressable store: KEY_W-bit key -> DATA_W-bit data, DEPTH entries.
//  Supports search, write (insert-or-update), delete and flush. Every entry has a valid bit.
//  Only one op is in flight at a time, through a 3-state FSM; the response is a one-cycle pulse.
//  Successor to the fixed 16x16 CAM; it sits between the lookup requester and its consumer.
// PARAMETERS
//  KEY_W   16  key width (bits)
//  DATA_W  16  stored data width (bits)
//  DEPTH   16  entry count, >=2; AW = $clog2(DEPTH)
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        synchronous active-low reset
//  cam_enable  in   1        global enable; when low, no new op is accepted
//  op_valid    in   1        request valid
//  op_ready    out  1        request accepted when op_valid & op_ready
//  op_code     in   2        00 search, 01 write, 10 delete, 11 flush
//  op_key      in   KEY_W    key for search/write/delete
//  op_data     in   DATA_W   data for write
//  rsp_valid   out  1        one-cycle response pulse
//  rsp_hit     out  1        key matched a valid entry
//  rsp_addr    out  AW       entry index that was hit, allocated or evicted
//  rsp_data    out  DATA_W   stored data (search hit only; else 0)
//  rsp_err     out  1        write rejected because the store is full
//  cam_count   out  AW+1     number of valid entries
//  cam_full    out  1        cam_count == DEPTH
// BEHAVIOUR
//  Reset: all valid bits cleared; victim ptr=0; cam_count=0; all rsp_* =0; FSM=IDLE; data array not reset.
//  FSM IDLE: op_ready = cam_enable. On accept (cycle T): latch op_code/key/data -> MATCH.
//  FSM MATCH (T+1): register match_vec[i] = valid[i] & (key[i]==op_key), and free_vec = ~valid -> RESP.
//  FSM RESP (T+2): commit the op, pulse rsp_valid, update cam_count -> IDLE. Next accept is at T+3 or later.
//  op_ready is low in MATCH/RESP. If cam_enable drops mid-op, the in-flight op still completes.
//  Hit index = lowest set bit of match_vec; free index = lowest set bit of free_vec.
//  search: hit -> rsp_hit=1, rsp_addr=idx, rsp_data=data[idx]; miss -> rsp_hit=0, rsp_addr=0, rsp_data=0.
//  write hit: overwrite data[idx]; rsp_hit=1; rsp_addr=idx; count unchanged.
//  write miss, not full: allocate free idx (key, data, valid=1); rsp_hit=0; rsp_addr=idx; count+1.
//  write miss, full: behaviour per CONFIGURATION.
//  delete: hit -> valid[idx]=0, rsp_hit=1, rsp_addr=idx, count-1; miss -> rsp_hit=0, no state change.
//  flush: all valid cleared; count=0; victim ptr=0; rsp_hit=0; rsp_err=0.
//  rsp_err is 0 for every op except a rejected write.
//  Duplicate keys are never created, because write updates the existing entry.
//  Victim pointer wraps DEPTH-1 -> 0.
//  rsp_* outputs hold 0 whenever rsp_valid=0.
//  rst_n low during MATCH or RESP: op abandoned, no rsp_valid, store returns to reset state.
// CONFIGURATION
//  CAM_EVICT_EN defined: a write miss while full replaces entry[victim ptr].
//    rsp_hit=0; rsp_err=0; rsp_addr=victim; ptr=ptr+1 mod DEPTH; count stays DEPTH.
//  CAM_EVICT_EN undefined: a write miss while full leaves the store unchanged.
//    rsp_err=1; rsp_addr=0; no victim pointer logic is instantiated.
// STRUCTURE
//  cam_pkg: op-code localparams (CAM_OP_SEARCH/WRITE/DELETE/FLUSH) and FSM state encoding (IDLE/MATCH/RESP).
//  Sub-module cam_prio_enc #(N): lowest-index priority encoder, outputs idx[$clog2(N)] and any.
//  It is instantiated twice: once for match_vec, once for free_vec.
// TESTING  (DEPTH=16, KEY_W=16, DATA_W=16)
//  1. write 0x0251/0x00AF, then write 0x0252/0x000F -> rsp_hit=0, rsp_addr 0 then 1; cam_count=2.
//  2. search 0x0251 -> rsp_valid 2 cycles after accept, rsp_hit=1, addr=0, data=0x00AF.
//     Then search 0x0069 -> rsp_hit=0, data=0.
//  3. write 0x0251/0x0012 -> rsp_hit=1, addr=0, count stays 2; a following search returns 0x0012.
//  4. delete 0x0252 -> rsp_hit=1, addr=1, count=1; then write 0x0069/0x0012 -> allocated addr=1.
//  5. fill all 16 entries, then write new key 0x1234:
//     without CAM_EVICT_EN -> rsp_err=1 and the store is unchanged;
//     with CAM_EVICT_EN -> addr=0 evicted, a second overflow write evicts addr=1.
//  6. flush -> count=0, cam_full=0.
//     Separately, pull rst_n low in the MATCH cycle of a write -> no rsp_valid, count=0, op_ready=1 after reset.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: op-code encodings and FSM state type shared by the CAM store
package cam_pkg;
  localparam logic [1:0] CAM_OP_SEARCH = 2'b00;
  localparam logic [1:0] CAM_OP_WRITE  = 2'b01;
  localparam logic [1:0] CAM_OP_DELETE = 2'b10;
  localparam logic [1:0] CAM_OP_FLUSH  = 2'b11;
  typedef enum logic [1:0] {IDLE, MATCH, RESP} cam_state_t;
endpackage

// File: rtl/cam_prio_enc.sv
// cam_prio_enc: lowest-index priority encoder
module cam_prio_enc #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) idx = W'(i);
  end
endmodule

// File: rtl/cam_assoc_store.sv
// cam_assoc_store: key->data content-addressable store with search/write/delete/flush
// CAM_EVICT_EN enables round-robin eviction on a write miss while full.
module cam_assoc_store
  import cam_pkg::*;
#(
  parameter int KEY_W  = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_enable,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [KEY_W-1:0]  op_key,
  input  logic [DATA_W-1:0] op_data,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [AW-1:0]     rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [AW:0]       cam_count,
  output logic              cam_full
);
  cam_state_t state, state_n;
  logic [1:0] op_q;
  logic [KEY_W-1:0] key_q;
  logic [DATA_W-1:0] data_q;
  logic [KEY_W-1:0] key_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] valid, match_vec, free_vec;
  logic [AW-1:0] hit_idx, free_idx, miss_addr, wr_idx;
  logic hit_any, free_any, accept, wr_miss, alloc, full_miss, del_hit, commit;
  cam_prio_enc #(.N(DEPTH)) u_hit (.vec(match_vec), .idx(hit_idx), .any(hit_any));
  cam_prio_enc #(.N(DEPTH)) u_free (.vec(free_vec), .idx(free_idx), .any(free_any));
`ifdef CAM_EVICT_EN
  logic [AW-1:0] victim;
  always_ff @(posedge clk)
    if (!rst_n || (rsp_valid && op_q == CAM_OP_FLUSH)) victim <= '0;
    else if (full_miss) victim <= (victim == AW'(DEPTH - 1)) ? '0 : victim + 1'b1;
`endif
  always_comb begin
    op_ready  = state == IDLE && cam_enable;
    accept    = op_ready && op_valid;
    state_n   = state == IDLE ? (accept ? MATCH : IDLE) : state == MATCH ? RESP : IDLE;
    rsp_valid = state == RESP && rst_n;
    rsp_hit   = rsp_valid && hit_any && op_q != CAM_OP_FLUSH;
    wr_miss   = rsp_valid && op_q == CAM_OP_WRITE && !hit_any;
    alloc     = wr_miss && free_any;
    full_miss = wr_miss && !free_any;
    del_hit   = rsp_hit && op_q == CAM_OP_DELETE;
`ifdef CAM_EVICT_EN
    miss_addr = free_any ? free_idx : victim;
    commit    = (rsp_hit && op_q == CAM_OP_WRITE) || wr_miss;
    rsp_err   = 1'b0;
`else
    miss_addr = free_any ? free_idx : '0;
    commit    = (rsp_hit && op_q == CAM_OP_WRITE) || alloc;
    rsp_err   = full_miss;
`endif
    wr_idx    = hit_any ? hit_idx : miss_addr;
    rsp_addr  = rsp_hit ? hit_idx : wr_miss ? miss_addr : '0;
    rsp_data  = (rsp_hit && op_q == CAM_OP_SEARCH) ? data_mem[hit_idx] : '0;
    cam_full  = cam_count == (AW+1)'(DEPTH);
  end
  always_ff @(posedge clk)
    if (commit) begin
      key_mem[wr_idx]  <= key_q;
      data_mem[wr_idx] <= data_q;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      valid     <= '0;
      cam_count <= '0;
      match_vec <= '0;
      free_vec  <= '0;
      op_q      <= CAM_OP_SEARCH;
      key_q     <= '0;
      data_q    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q   <= op_code;
        key_q  <= op_key;
        data_q <= op_data;
      end
      if (state == MATCH) begin
        for (int i = 0; i < DEPTH; i++) match_vec[i] <= valid[i] && key_mem[i] == key_q;
        free_vec <= ~valid;
      end
      if (rsp_valid && op_q == CAM_OP_FLUSH) begin
        valid     <= '0;
        cam_count <= '0;
      end
      if (alloc) begin
        valid[free_idx] <= 1'b1;
        cam_count       <= cam_count + 1'b1;
      end
      if (del_hit) begin
        valid[hit_idx] <= 1'b0;
        cam_count      <= cam_count - 1'b1;
      end
    end
endmodule

// File: tb/tb_cam_assoc_store.sv
// tb_cam_assoc_store: directed scoreboard bench for cam_assoc_store (DEPTH=16)
module tb_cam_assoc_store;
  localparam logic [1:0] S = 2'b00, W = 2'b01, D = 2'b10, F = 2'b11;
  logic clk = 0, rst_n = 0, cam_enable = 1, op_valid = 0;
  logic [1:0] op_code = 0;
  logic [15:0] op_key = 0, op_data = 0;
  logic op_ready, rsp_valid, rsp_hit, rsp_err, cam_full;
  logic [3:0] rsp_addr;
  logic [15:0] rsp_data;
  logic [4:0] cam_count;
  typedef struct packed {logic hit; logic [3:0] addr; logic [15:0] data; logic err;} exp_t;
  exp_t sb [$];
  int ncmp = 0, nfail = 0;
  cam_assoc_store dut (.clk(clk), .rst_n(rst_n), .cam_enable(cam_enable), .op_valid(op_valid),
    .op_ready(op_ready), .op_code(op_code), .op_key(op_key), .op_data(op_data),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .cam_count(cam_count), .cam_full(cam_full));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic do_op(input logic [1:0] op, input logic [15:0] k, input logic [15:0] d,
                       input logic eh, input logic [3:0] ea, input logic [15:0] ed, input logic ee);
    int n;
    exp_t e;
    n = 0;
    while (!op_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready", op_ready, 1);
    op_valid = 1; op_code = op; op_key = k; op_data = d;
    @(posedge clk);
    sb.push_back('{eh, ea, ed, ee});
    @(negedge clk);
    op_valid = 0;
    n = 1;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    chk("latency", n, 2);
    e = sb.pop_front();
    chk("rsp_hit", rsp_hit, e.hit);
    chk("rsp_addr", rsp_addr, e.addr);
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_err", rsp_err, e.err);
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 0);
  endtask
  initial begin
    int seen;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_ready", op_ready, 1);
    chk("rst_rsp", {rsp_valid, rsp_hit, rsp_err, rsp_addr, rsp_data}, 0);
    chk("rst_count", cam_count, 0);
    chk("rst_full", cam_full, 0);
    do_op(W, 16'h0251, 16'h00AF, 0, 0, 0, 0);
    do_op(W, 16'h0252, 16'h000F, 0, 1, 0, 0);
    chk("count2", cam_count, 2);
    do_op(S, 16'h0251, 0, 1, 0, 16'h00AF, 0);
    do_op(S, 16'h0069, 0, 0, 0, 0, 0);
    do_op(W, 16'h0251, 16'h0012, 1, 0, 0, 0);
    chk("count_upd", cam_count, 2);
    do_op(S, 16'h0251, 0, 1, 0, 16'h0012, 0);
    do_op(D, 16'h0252, 0, 1, 1, 0, 0);
    chk("count_del", cam_count, 1);
    do_op(S, 16'h0252, 0, 0, 0, 0, 0);
    do_op(W, 16'h0069, 16'h0012, 0, 1, 0, 0);
    for (int i = 2; i < 16; i++) do_op(W, 16'h1000 + 16'(i), 16'(i * 3), 0, 4'(i), 0, 0);
    chk("count_full", cam_count, 16);
    chk("full", cam_full, 1);
    do_op(S, 16'h100F, 0, 1, 15, 16'd45, 0);
`ifdef CAM_EVICT_EN
    do_op(W, 16'h1234, 16'h5555, 0, 0, 0, 0);
    do_op(W, 16'h4321, 16'h0006, 0, 1, 0, 0);
    chk("count_evict", cam_count, 16);
    do_op(S, 16'h1234, 0, 1, 0, 16'h5555, 0);
    do_op(S, 16'h4321, 0, 1, 1, 16'h0006, 0);
    do_op(S, 16'h0251, 0, 0, 0, 0, 0);
    do_op(S, 16'h0069, 0, 0, 0, 0, 0);
`else
    do_op(W, 16'h1234, 16'h5555, 0, 0, 0, 1);
    chk("count_rej", cam_count, 16);
    do_op(S, 16'h1234, 0, 0, 0, 0, 0);
    do_op(S, 16'h0251, 0, 1, 0, 16'h0012, 0);
    do_op(S, 16'h0069, 0, 1, 1, 16'h0012, 0);
`endif
    do_op(D, 16'hBEEF, 0, 0, 0, 0, 0);
    chk("count_delmiss", cam_count, 16);
    cam_enable = 0;
    @(negedge clk);
    chk("ready_dis", op_ready, 0);
    cam_enable = 1;
    do_op(F, 0, 0, 0, 0, 0, 0);
    chk("count_flush", cam_count, 0);
    chk("full_flush", cam_full, 0);
    do_op(S, 16'h1005, 0, 0, 0, 0, 0);
    do_op(W, 16'h0AAA, 16'h00BB, 0, 0, 0, 0);
    op_valid = 1; op_code = W; op_key = 16'h7777; op_data = 16'h0001;
    @(negedge clk);
    op_valid = 0;
    rst_n = 0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      seen += int'(rsp_valid);
    end
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      seen += int'(rsp_valid);
    end
    chk("abort_rsp", seen, 0);
    chk("abort_count", cam_count, 0);
    chk("abort_ready", op_ready, 1);
    do_op(S, 16'h7777, 0, 0, 0, 0, 0);
    do_op(S, 16'h0AAA, 0, 0, 0, 0, 0);
    do_op(W, 16'h7777, 16'h0009, 0, 0, 0, 0);
    chk("count_end", cam_count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
